line_refill_responder: RTL
==========================

Name: line_refill_responder

Overview:
- Memory-side responder for the data cache's line-refill interface; the cache (initiator) stalls the pipeline on a miss and issues requests here.
- Serves line reads as multi-beat bursts after a fixed access latency.
- Accepts single-word writes with byte strobes and acknowledges them.
- Owns the backing word store behind the cache; sits between the cache and the top-level memory map.

Parameters:
- DW, 32, data word width in bits
- AW, 32, request address width in bits
- WORDS_PER_LINE, 4, beats per refill burst; power of two, at least 2
- LATENCY, 3, idle cycles between request acceptance and first response beat; 0 allowed
- DEPTH_WORDS, 1024, backing store size in words; power of two

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid_i  in  1  initiator presents a request
- req_ready_o  out  1  responder can accept a request this cycle
- req_write_i  in  1  1 = word write, 0 = line read
- req_addr_i  in  AW  byte address
- req_wdata_i  in  DW  write data
- req_wstrb_i  in  DW/8  byte enables for a write
- resp_valid_o  out  1  response beat valid
- resp_ready_i  in  1  initiator accepts the beat
- resp_data_o  out  DW  read beat data; 0 for a write acknowledge
- resp_last_o  out  1  final beat of the response
- busy_o  out  1  a transaction is in progress (state not IDLE)

Behaviour:
- States: IDLE, WAIT, BURST, WACK.
- Reset (rst low, asynchronous): state IDLE. resp_valid_o, resp_last_o, resp_data_o, busy_o = 0; req_ready_o = 1. Store contents are unaffected and undefined at power-up.
- req_ready_o = 1 only in IDLE. A request is accepted on a clock edge where req_valid_i and req_ready_o are both 1.
- On acceptance, latch write, address, wdata and wstrb. Load the latency counter with LATENCY. Go to WAIT, or directly to BURST/WACK when LATENCY = 0.
- WAIT: decrement the counter each cycle. When the count reaches 0, go to BURST (read) or WACK (write). The first response beat is therefore visible exactly LATENCY+1 cycles after the accepting edge.
- Read addressing:
  - Base word index = (req_addr_i >> 2), with its low log2(WORDS_PER_LINE) bits cleared (line aligned).
  - Store index = word index mod DEPTH_WORDS (upper bits ignored; wraps).
  - Beats are returned in ascending order from the base: no critical-word-first, no wrap inside the line.
- BURST:
  - resp_valid_o = 1; resp_data_o holds the current word.
  - resp_last_o = 1 on beat WORDS_PER_LINE-1 only.
  - Beat index advances only on resp_valid_o & resp_ready_i.
  - While resp_ready_i = 0, resp_data_o and resp_last_o hold stable.
  - Handshake on the last beat returns to IDLE; req_ready_o = 1 in the following cycle.
- Write:
  - Applied to the store on the edge entering WACK. Only bytes with wstrb = 1 change.
  - Word index = req_addr_i[.. :2] mod DEPTH_WORDS; low two address bits ignored.
  - WACK: one beat with resp_valid_o = 1, resp_last_o = 1, resp_data_o = 0. Held until resp_ready_i; then IDLE.
- Reads always see all earlier acknowledged writes; there is never more than one outstanding transaction.
- req_valid_i outside IDLE is ignored, with no side effects.
- Reset asserted mid-WAIT or mid-BURST aborts the transaction. resp_valid_o drops immediately (asynchronously). A write latched but not yet applied is discarded.
- resp_data_o is driven from a register, not combinationally from req_addr_i.

Decomposition:
- Shared package line_refill_pkg holds:
  - the state enum (IDLE, WAIT, BURST, WACK)
  - the function computing the line-aligned word index
  - localparams OFF_W = log2(WORDS_PER_LINE), IDX_W = log2(DEPTH_WORDS), LAT_W
- One sub-module, refill_word_store: DW x DEPTH_WORDS array with synchronous registered read port and byte-strobed synchronous write port, no reset.

Test Plan:
- Reset with rst = 0 mid-BURST -> resp_valid_o = 0 immediately, req_ready_o = 1, busy_o = 0. After release, a new request is accepted next edge.
- Write addr 0x100, data 0xDEADBEEF, wstrb 0xF, LATENCY = 3 -> one ack beat (last = 1, data = 0) 4 cycles after acceptance. Read 0x10C -> beats at word indices 0x40..0x43, beat0 = 0xDEADBEEF, last = 1 on beat3 only.
- Preload words 0x40..0x43 with 0xA0..0xA3 by writes. Read addr 0x108 -> beats 0xA0, 0xA1, 0xA2, 0xA3 (aligned, ascending).
- Same read with resp_ready_i low for 2 cycles on beat1 -> beat1 data 0xA1 held stable 3 cycles; 4 beats total, no skip or repeat.
- Word 0x40 = 0x11223344, write wstrb 0b0101 with data 0xAABBCCDD -> readback 0x11BB33DD. req_valid_i held high during BURST is ignored, with no second transaction.
- LATENCY = 0 build -> first beat the cycle after acceptance. Address 0x1000 with DEPTH_WORDS = 1024 aliases to word 0 (wrap).

Source files
------------

// File: rtl/line_refill_pkg.sv
// Shared types and helpers for the cache line-refill responder.
package line_refill_pkg;

  typedef enum logic [1:0] {StIdle, StWait, StBurst, StWack} state_e;

  function automatic int unsigned lat_width(input int unsigned lat);
    return (lat > 0) ? $clog2(lat + 1) : 1;
  endfunction

  // Word index of the first word of the line holding byte address addr.
  function automatic logic [63:0] line_word_index(input logic [63:0] addr,
                                                  input int unsigned off_w);
    logic [63:0] word;
    word = addr >> 2;
    return (word >> off_w) << off_w;
  endfunction

  localparam int unsigned DEF_WORDS_PER_LINE = 4;
  localparam int unsigned DEF_DEPTH_WORDS    = 1024;
  localparam int unsigned DEF_LATENCY        = 3;

  localparam int unsigned OFF_W = $clog2(DEF_WORDS_PER_LINE);
  localparam int unsigned IDX_W = $clog2(DEF_DEPTH_WORDS);
  localparam int unsigned LAT_W = lat_width(DEF_LATENCY);

endpackage

// File: rtl/line_refill_responder_store.sv
// Backing word store: registered read port, byte-strobed write port, no reset.
module refill_word_store #(
  parameter int unsigned DW          = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [DW-1:0]     wdata,
  input  logic [DW/8-1:0]   wstrb,
  input  logic [IDX_W-1:0]  ridx,
  output logic [DW-1:0]     rdata
);

  logic [DW-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DW / 8; b++) begin
        if (wstrb[b]) mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    rdata <= mem[ridx];
  end

endmodule

// File: rtl/line_refill_responder.sv
// Memory-side responder for data-cache line refills and single-word strobed writes.
module line_refill_responder
  import line_refill_pkg::*;
#(
  parameter int unsigned DW             = 32,
  parameter int unsigned AW             = 32,
  parameter int unsigned WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter int unsigned LATENCY        = DEF_LATENCY,
  parameter int unsigned DEPTH_WORDS    = DEF_DEPTH_WORDS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_write_i,
  input  logic [AW-1:0]   req_addr_i,
  input  logic [DW-1:0]   req_wdata_i,
  input  logic [DW/8-1:0] req_wstrb_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [DW-1:0]   resp_data_o,
  output logic            resp_last_o,
  output logic            busy_o
);

  localparam int unsigned OffW = $clog2(WORDS_PER_LINE);
  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
  localparam int unsigned LatW = lat_width(LATENCY);
  localparam int unsigned SW   = DW / 8;

  localparam logic [LatW-1:0] LatInit  = LatW'(LATENCY);
  localparam logic [OffW-1:0] LastBeat = OffW'(WORDS_PER_LINE - 1);

  state_e           state_q;
  logic [LatW-1:0]  cnt_q;
  logic [OffW-1:0]  beat_q;
  logic [IdxW-1:0]  base_q;
  logic [IdxW-1:0]  widx_q;
  logic             write_q;
  logic [DW-1:0]    wdata_q;
  logic [SW-1:0]    wstrb_q;

  logic [IdxW-1:0]  req_line;
  logic [IdxW-1:0]  req_word;
  logic             accept;
  logic             beat_done;
  logic             wait_done;

  logic [IdxW-1:0]  rd_idx;
  logic [DW-1:0]    rd_data;
  logic             st_we;
  logic [IdxW-1:0]  st_widx;
  logic [DW-1:0]    st_wdata;
  logic [SW-1:0]    st_wstrb;

  // Upper address bits beyond the store size are dropped, so indices wrap.
  assign req_line  = IdxW'(line_word_index(64'(req_addr_i), OffW));
  assign req_word  = IdxW'(req_addr_i >> 2);

  assign accept    = req_valid_i && (state_q == StIdle);
  assign beat_done = (state_q == StBurst) && resp_ready_i;
  assign wait_done = (state_q == StWait) && (cnt_q == LatW'(1));

  // Address the word that must be on resp_data_o after the next edge; a stalled
  // beat re-reads its own word so the output holds.
  assign rd_idx = (state_q == StIdle) ? req_line
                                      : base_q + IdxW'(beat_q) + IdxW'(beat_done);

  always_comb begin
    st_we    = 1'b0;
    st_widx  = widx_q;
    st_wdata = wdata_q;
    st_wstrb = wstrb_q;
    if (LATENCY == 0) begin
      st_we    = accept && req_write_i;
      st_widx  = req_word;
      st_wdata = req_wdata_i;
      st_wstrb = req_wstrb_i;
    end else begin
      st_we    = wait_done && write_q;
    end
  end

  refill_word_store #(
    .DW          (DW),
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IdxW)
  ) u_store (
    .clk   (clk),
    .we    (st_we),
    .widx  (st_widx),
    .wdata (st_wdata),
    .wstrb (st_wstrb),
    .ridx  (rd_idx),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      beat_q  <= '0;
      base_q  <= '0;
      widx_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            write_q <= req_write_i;
            base_q  <= req_line;
            widx_q  <= req_word;
            wdata_q <= req_wdata_i;
            wstrb_q <= req_wstrb_i;
            cnt_q   <= LatInit;
            beat_q  <= '0;
            if (LATENCY == 0) state_q <= req_write_i ? StWack : StBurst;
            else              state_q <= StWait;
          end
        end
        StWait: begin
          if (cnt_q == LatW'(1)) state_q <= write_q ? StWack : StBurst;
          else                   cnt_q   <= cnt_q - LatW'(1);
        end
        StBurst: begin
          if (resp_ready_i) begin
            beat_q <= beat_q + OffW'(1);
            if (beat_q == LastBeat) state_q <= StIdle;
          end
        end
        StWack: begin
          if (resp_ready_i) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready_o  = (state_q == StIdle);
  assign busy_o       = (state_q != StIdle);
  assign resp_valid_o = (state_q == StBurst) || (state_q == StWack);
  assign resp_last_o  = ((state_q == StBurst) && (beat_q == LastBeat)) || (state_q == StWack);
  assign resp_data_o  = (state_q == StBurst) ? rd_data : '0;

endmodule
